// File: rtl/float_int_pkg.sv
// float_int_pkg: shared definitions for the float-to-integer converter.
//   fti_bias   - exponent bias for a given exponent field width
//   fti_umax   - all-ones unsigned saturation value for an integer width
//   fti_smax   - most positive two's-complement value for an integer width
//   fti_smin   - bit pattern (and magnitude) of the most negative value
//   fti_rnd_e  - rounding mode encodings carried with each operand
// Saturation helpers return FTI_MAX_W-bit values; callers slice to INT_W.
package float_int_pkg;

    localparam int FTI_MAX_W = 128;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } fti_rnd_e;

    function automatic int fti_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [FTI_MAX_W-1:0] fti_umax(input int w);
        return (FTI_MAX_W'(1) << w) - FTI_MAX_W'(1);
    endfunction

    function automatic logic [FTI_MAX_W-1:0] fti_smax(input int w);
        return (FTI_MAX_W'(1) << (w - 1)) - FTI_MAX_W'(1);
    endfunction

    function automatic logic [FTI_MAX_W-1:0] fti_smin(input int w);
        return FTI_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fti_round_sat.sv
// fti_round_sat: combinational round / saturate / negate for the last stage
// of the float-to-integer pipeline.
// Ports:
//   i_sign     operand sign
//   i_signed   1 = signed result, 0 = unsigned
//   i_round    rounding mode (RND_TRUNC / RND_RNE)
//   i_mag      aligned integer magnitude, INT_W+1 bits (top bit is carry room)
//   i_guard    first discarded fraction bit
//   i_sticky   OR of all lower discarded bits
//   i_ovf      magnitude out of range (exponent too large, or infinity)
//   i_nan      operand is NaN
//   o_z        integer result
//   o_invalid  result saturated or operand unrepresentable
//   o_inexact  nonzero fraction discarded (suppressed when invalid)
module fti_round_sat
    import float_int_pkg::*;
#(
    parameter int INT_W = 32
) (
    input  logic             i_sign,
    input  logic             i_signed,
    input  logic             i_round,
    input  logic [INT_W:0]   i_mag,
    input  logic             i_guard,
    input  logic             i_sticky,
    input  logic             i_ovf,
    input  logic             i_nan,
    output logic [INT_W-1:0] o_z,
    output logic             o_invalid,
    output logic             o_inexact
);

    localparam logic [FTI_MAX_W-1:0] L_UMAX_F = fti_umax(INT_W);
    localparam logic [FTI_MAX_W-1:0] L_SMAX_F = fti_smax(INT_W);
    localparam logic [FTI_MAX_W-1:0] L_SMIN_F = fti_smin(INT_W);

    localparam logic [INT_W-1:0] L_UMAX     = L_UMAX_F[INT_W-1:0];
    localparam logic [INT_W-1:0] L_SMAX     = L_SMAX_F[INT_W-1:0];
    localparam logic [INT_W-1:0] L_SMIN     = L_SMIN_F[INT_W-1:0];
    // Magnitude limits compared against the INT_W+1 bit rounded magnitude.
    localparam logic [INT_W:0]   L_SMAX_MAG = {1'b0, L_SMAX};
    localparam logic [INT_W:0]   L_SMIN_MAG = {1'b0, L_SMIN};
    localparam logic [INT_W:0]   L_ONE      = (INT_W+1)'(1);

    logic           w_inc;
    logic [INT_W:0] w_rmag;
    logic [INT_W:0] w_neg;

    // Round-to-nearest-even: bump when above half, or exactly half with odd lsb.
    assign w_inc  = (i_round == RND_RNE) && i_guard && (i_sticky || i_mag[0]);
    assign w_rmag = i_mag + (w_inc ? L_ONE : '0);
    assign w_neg  = ~w_rmag + L_ONE;

    always_comb begin
        o_z       = '0;
        o_invalid = 1'b0;
        o_inexact = i_guard || i_sticky;

        if (i_nan) begin
            o_invalid = 1'b1;
        end else if (!i_signed) begin
            if (i_sign) begin
                // Negatives that round to zero are legal zeros; anything else is invalid.
                if (i_ovf || (w_rmag != '0)) begin
                    o_invalid = 1'b1;
                end
            end else if (i_ovf || w_rmag[INT_W]) begin
                o_z       = L_UMAX;
                o_invalid = 1'b1;
            end else begin
                o_z = w_rmag[INT_W-1:0];
            end
        end else begin
            if (i_sign) begin
                // -2^(INT_W-1) itself is representable, so only strictly greater saturates.
                if (i_ovf || (w_rmag > L_SMIN_MAG)) begin
                    o_z       = L_SMIN;
                    o_invalid = 1'b1;
                end else begin
                    o_z = w_neg[INT_W-1:0];
                end
            end else if (i_ovf || (w_rmag > L_SMAX_MAG)) begin
                o_z       = L_SMAX;
                o_invalid = 1'b1;
            end else begin
                o_z = w_rmag[INT_W-1:0];
            end
        end

        if (o_invalid) begin
            o_inexact = 1'b0;
        end
    end

endmodule

// File: rtl/float_to_int_pipe.sv
// float_to_int_pipe: 3-stage float {sign, exp, man} to signed/unsigned integer
// converter with per-operand rounding mode and valid/ready back-pressure.
// Stages: decode -> align (shift, guard, sticky) -> round/saturate (registered out).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_a              float operand, FLT_W bits
//   in_signed         1 = signed two's-complement result
//   in_round          0 = truncate, 1 = round-to-nearest-even
//   in_valid/in_ready input handshake
//   out_z             integer result
//   out_invalid       NaN, infinity, overflow or unrepresentable negative
//   out_inexact       fraction discarded (never with out_invalid)
//   out_valid/out_ready output handshake
// A stalled output holds the whole pipeline; in_ready is that global enable.
module float_to_int_pipe
    import float_int_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32,
    parameter int FLT_W = EXP_W + MAN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FLT_W-1:0] in_a,
    input  logic             in_signed,
    input  logic             in_round,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [INT_W-1:0] out_z,
    output logic             out_invalid,
    output logic             out_inexact,
    output logic             out_valid,
    input  logic             out_ready
);

    // Fixed-point alignment buffer: INT_W+1 integer bits and MAN_W+1 fraction
    // bits, enough to hold guard and sticky for exponents down to -1.
    localparam int FRAC_W = MAN_W + 1;
    localparam int FIX_W  = INT_W + 1 + FRAC_W;
    localparam logic [EXP_W:0] L_BIAS = (EXP_W+1)'(fti_bias(EXP_W));

    logic [2:0] r_vld_pipe;
    logic       w_adv;

    assign w_adv     = !r_vld_pipe[2] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[2];

    // ---------------- stage 1: decode ----------------
    logic [EXP_W-1:0]        w_exp;
    logic [MAN_W-1:0]        w_man;
    logic signed [EXP_W:0]   w_e;

    assign w_exp = in_a[FLT_W-2:MAN_W];
    assign w_man = in_a[MAN_W-1:0];
    assign w_e   = $signed({1'b0, w_exp} - L_BIAS);

    logic                  r1_sign, r1_signed, r1_round;
    logic signed [EXP_W:0] r1_exp;
    logic [MAN_W:0]        r1_sig;
    logic                  r1_zero, r1_special, r1_man_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_sign    <= 1'b0;
            r1_signed  <= 1'b0;
            r1_round   <= 1'b0;
            r1_exp     <= '0;
            r1_sig     <= '0;
            r1_zero    <= 1'b0;
            r1_special <= 1'b0;
            r1_man_nz  <= 1'b0;
        end else if (w_adv) begin
            r1_sign    <= in_a[FLT_W-1];
            r1_signed  <= in_signed;
            r1_round   <= in_round;
            r1_exp     <= w_e;
            r1_sig     <= {1'b1, w_man};
            r1_zero    <= (w_exp == '0);
            r1_special <= (&w_exp);
            r1_man_nz  <= (w_man != '0);
        end
    end

    // ---------------- stage 2: align ----------------
    int               w_e_int;
    logic [FIX_W-1:0] w_sig_ext;
    logic [FIX_W-1:0] w_fix;
    logic [INT_W:0]   w_mag;
    logic             w_guard, w_sticky, w_ovf, w_nan;

    assign w_e_int   = int'(r1_exp);
    assign w_sig_ext = FIX_W'(r1_sig);
    assign w_nan     = r1_special && r1_man_nz;

    // The significand sits at the buffer lsb as value/2, so a left shift of
    // e+1 lands its binary point on the integer/fraction boundary.
    always_comb begin
        w_fix    = '0;
        w_mag    = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_ovf    = 1'b0;
        if (r1_special) begin
            w_ovf = 1'b1;
        end else if (r1_zero) begin
            w_sticky = r1_man_nz;
        end else if (w_e_int >= INT_W) begin
            w_ovf = 1'b1;
        end else if (w_e_int < -1) begin
            w_sticky = 1'b1;
        end else begin
            w_fix    = w_sig_ext << (w_e_int + 1);
            w_mag    = w_fix[FIX_W-1:FRAC_W];
            w_guard  = w_fix[FRAC_W-1];
            w_sticky = |w_fix[FRAC_W-2:0];
        end
    end

    logic           r2_sign, r2_signed, r2_round;
    logic [INT_W:0] r2_mag;
    logic           r2_guard, r2_sticky, r2_ovf, r2_nan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_sign   <= 1'b0;
            r2_signed <= 1'b0;
            r2_round  <= 1'b0;
            r2_mag    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_ovf    <= 1'b0;
            r2_nan    <= 1'b0;
        end else if (w_adv) begin
            r2_sign   <= r1_sign;
            r2_signed <= r1_signed;
            r2_round  <= r1_round;
            r2_mag    <= w_mag;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
            r2_ovf    <= w_ovf;
            r2_nan    <= w_nan;
        end
    end

    // ---------------- stage 3: round / saturate ----------------
    logic [INT_W-1:0] w_z;
    logic             w_invalid, w_inexact;

    fti_round_sat #(
        .INT_W (INT_W)
    ) u_round_sat (
        .i_sign    (r2_sign),
        .i_signed  (r2_signed),
        .i_round   (r2_round),
        .i_mag     (r2_mag),
        .i_guard   (r2_guard),
        .i_sticky  (r2_sticky),
        .i_ovf     (r2_ovf),
        .i_nan     (r2_nan),
        .o_z       (w_z),
        .o_invalid (w_invalid),
        .o_inexact (w_inexact)
    );

    logic [INT_W-1:0] r_out_z;
    logic             r_out_invalid, r_out_inexact;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_z       <= '0;
            r_out_invalid <= 1'b0;
            r_out_inexact <= 1'b0;
        end else if (w_adv && r_vld_pipe[1]) begin
            r_out_z       <= w_z;
            r_out_invalid <= w_invalid;
            r_out_inexact <= w_inexact;
        end
    end

    assign out_z       = r_out_z;
    assign out_invalid = r_out_invalid;
    assign out_inexact = r_out_inexact;

    // Valid shift register; bit 2 is the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[1:0], in_valid};
        end
    end

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Directed bench for float_to_int_pipe (EXP_W=8, MAN_W=23, INT_W=32).
// Results are compared as {invalid, inexact, z}.
module tb_float_to_int_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] in_a;
    logic        in_signed;
    logic        in_round;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_z;
    logic        out_invalid;
    logic        out_inexact;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    float_to_int_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_a        (in_a),
        .in_signed   (in_signed),
        .in_round    (in_round),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_z       (out_z),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single operand through an idle pipe: checks 3-cycle latency and result.
    task automatic run_one(input string tag, input logic [31:0] a, input logic sg,
                           input logic rd, input logic [33:0] exp);
        logic [2:0] lat;
        @(negedge clk);
        in_a = a; in_signed = sg; in_round = rd; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lat[k] = out_valid;
            if (k < 2) @(posedge clk);
        end
        chk({tag, "/lat"}, {61'd0, lat}, 64'h4);
        chk(tag, {30'd0, out_invalid, out_inexact, out_z}, {30'd0, exp});
        @(posedge clk);
    endtask

    logic [31:0] bp_a[10];
    logic        bp_s[10];
    logic        bp_r[10];
    logic [33:0] bp_exp[10];
    logic [3:0]  pat;

    initial begin
        bp_a[0] = 32'h3F800000; bp_s[0] = 0; bp_r[0] = 0; bp_exp[0] = {2'b00, 32'd1};
        bp_a[1] = 32'h40000000; bp_s[1] = 1; bp_r[1] = 1; bp_exp[1] = {2'b00, 32'd2};
        bp_a[2] = 32'h40600000; bp_s[2] = 0; bp_r[2] = 1; bp_exp[2] = {2'b01, 32'd4};
        bp_a[3] = 32'h40600000; bp_s[3] = 1; bp_r[3] = 0; bp_exp[3] = {2'b01, 32'd3};
        bp_a[4] = 32'hC0400000; bp_s[4] = 1; bp_r[4] = 0; bp_exp[4] = {2'b00, 32'hFFFFFFFD};
        bp_a[5] = 32'hC0400000; bp_s[5] = 0; bp_r[5] = 1; bp_exp[5] = {2'b10, 32'd0};
        bp_a[6] = 32'h40A00000; bp_s[6] = 0; bp_r[6] = 0; bp_exp[6] = {2'b00, 32'd5};
        bp_a[7] = 32'h40C00000; bp_s[7] = 1; bp_r[7] = 1; bp_exp[7] = {2'b00, 32'd6};
        bp_a[8] = 32'h40E00000; bp_s[8] = 0; bp_r[8] = 1; bp_exp[8] = {2'b00, 32'd7};
        bp_a[9] = 32'h41000000; bp_s[9] = 1; bp_r[9] = 0; bp_exp[9] = {2'b00, 32'd8};
        pat = 4'b1001;

        rst = 1'b0; in_a = '0; in_signed = 0; in_round = 0; in_valid = 0; out_ready = 1;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset/out", {29'd0, out_valid, out_invalid, out_inexact, out_z}, 64'h0);
        chk("reset/in_ready", {63'd0, in_ready}, 64'h1);
        rst = 1'b0;

        // rounding
        run_one("3.0u",       32'h40400000, 0, 0, {2'b00, 32'd3});
        run_one("3.5rne",     32'h40600000, 0, 1, {2'b01, 32'd4});
        run_one("3.5trunc",   32'h40600000, 0, 0, {2'b01, 32'd3});
        run_one("2.5rne",     32'h40200000, 0, 1, {2'b01, 32'd2});
        run_one("0.5rne",     32'h3F000000, 0, 1, {2'b01, 32'd0});
        run_one("0.75rne",    32'h3F400000, 0, 1, {2'b01, 32'd1});
        // sign handling
        run_one("-1.0s",      32'hBF800000, 1, 0, {2'b00, 32'hFFFFFFFF});
        run_one("-1.0u",      32'hBF800000, 0, 0, {2'b10, 32'd0});
        run_one("-0.25u",     32'hBE800000, 0, 1, {2'b01, 32'd0});
        run_one("-0.0u",      32'h80000000, 0, 0, {2'b00, 32'd0});
        // saturation and range edges
        run_one("2^32u",      32'h4F800000, 0, 0, {2'b10, 32'hFFFFFFFF});
        run_one("maxexact_u", 32'h4F7FFFFF, 0, 0, {2'b00, 32'hFFFFFF00});
        run_one("-2^31s",     32'hCF000000, 1, 0, {2'b00, 32'h80000000});
        run_one("2^31s",      32'h4F000000, 1, 0, {2'b10, 32'h7FFFFFFF});
        run_one("maxexact_s", 32'h4EFFFFFF, 1, 1, {2'b00, 32'h7FFFFF80});
        // specials
        run_one("nan_u",      32'h7FC00000, 0, 0, {2'b10, 32'd0});
        run_one("nan_s",      32'h7FC00000, 1, 1, {2'b10, 32'd0});
        run_one("-inf_s",     32'hFF800000, 1, 0, {2'b10, 32'h80000000});
        run_one("+inf_u",     32'h7F800000, 0, 0, {2'b10, 32'hFFFFFFFF});
        run_one("denorm",     32'h00000001, 0, 0, {2'b01, 32'd0});

        // back-pressure stream, out_ready cycling 1-0-0-1
        fork
            begin : drv
                int idx;
                int g;
                idx = 0; g = 0;
                while (idx < 10 && g < 200) begin
                    @(negedge clk);
                    #1;
                    in_a = bp_a[idx]; in_signed = bp_s[idx]; in_round = bp_r[idx];
                    in_valid = 1'b1;
                    if (in_ready) idx++;
                    g++;
                end
                @(negedge clk);
                #1 in_valid = 1'b0;
            end
            begin : mon
                int c;
                int rx;
                logic stalled;
                logic [31:0] held;
                c = 0; rx = 0; stalled = 1'b0; held = '0;
                while (rx < 10 && c < 300) begin
                    @(negedge clk);
                    out_ready = pat[c % 4];
                    #1;
                    if (stalled) chk("bp/hold", {32'd0, out_z}, {32'd0, held});
                    chk("bp/in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
                    stalled = out_valid && !out_ready;
                    held = out_z;
                    if (out_valid && out_ready) begin
                        chk($sformatf("bp/res%0d", rx),
                            {30'd0, out_invalid, out_inexact, out_z}, {30'd0, bp_exp[rx]});
                        rx++;
                    end
                    c++;
                end
                if (rx < 10) chk("bp/timeout", 64'(rx), 64'd10);
                out_ready = 1'b1;
                @(negedge clk);
                #1 chk("bp/drain", {63'd0, out_valid}, 64'h0);
            end
        join
        out_ready = 1'b1;

        // reset with three operands in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_a = bp_a[k]; in_signed = 0; in_round = 0; in_valid = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("rst/pre", {63'd0, out_valid}, 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst/async", {29'd0, out_valid, out_invalid, out_inexact, out_z}, 64'h0);
        chk("rst/in_ready", {63'd0, in_ready}, 64'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                seen = seen | out_valid;
            end
            chk("rst/stale", {63'd0, seen}, 64'h0);
        end
        run_one("rst/next", 32'h40400000, 0, 0, {2'b00, 32'd3});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
